// File: rtl/sine_term.sv
// sin(x) ~= x - x^3/6 using a bit-serial restoring divide-by-6 on the supplied cube.
// Optional round-to-nearest of the quotient when SINE_ROUND_EN is defined.
module sine_term (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [6:0]  x,
  input  logic [20:0] x_cube,
  output logic [18:0] y,
  output logic        valid,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, DIV, SUB, DONE} state_t;

  state_t      r_state;
  state_t      w_next;

  logic [6:0]  r_x;
  logic [20:0] r_dvd;
  logic [20:0] r_quot;
  logic [2:0]  r_rem;
  logic [4:0]  r_cnt;
  logic [18:0] r_y;
  logic        r_valid;

  logic [3:0]  w_rem_sh;
  logic        w_ge6;
  logic [2:0]  w_rem_nxt;
  logic [20:0] w_q_final;
  logic [18:0] w_diff;

  // Remainder is always < 6, so three bits plus the incoming dividend bit suffice.
  assign w_rem_sh  = {r_rem, r_dvd[20]};
  assign w_ge6     = (w_rem_sh >= 4'd6);
  assign w_rem_nxt = w_ge6 ? 3'(w_rem_sh - 4'd6) : w_rem_sh[2:0];

`ifdef SINE_ROUND_EN
  // 2*rem >= 6 is the same as rem >= 3
  assign w_q_final = r_quot + {20'd0, (r_rem >= 3'd3)};
`else
  assign w_q_final = r_quot;
`endif

  assign w_diff = {r_x, 12'd0} - 19'(w_q_final);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = DIV;
      DIV:     if (r_cnt == 5'd0) w_next = SUB;
      SUB:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != IDLE);
  end

  // Dividend shifts out MSB-first while quotient bits shift in at the LSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x     <= '0;
      r_dvd   <= '0;
      r_quot  <= '0;
      r_rem   <= '0;
      r_cnt   <= '0;
      r_y     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= (r_state == DONE);
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_x    <= x;
            r_dvd  <= x_cube;
            r_quot <= '0;
            r_rem  <= '0;
            r_cnt  <= 5'd20;
          end
        end
        DIV: begin
          r_rem  <= w_rem_nxt;
          r_quot <= {r_quot[19:0], w_ge6};
          r_dvd  <= {r_dvd[19:0], 1'b0};
          if (r_cnt != 5'd0) r_cnt <= r_cnt - 5'd1;
        end
        SUB: begin
          r_y <= w_diff;
        end
        default: begin
        end
      endcase
    end
  end

  assign y     = r_y;
  assign valid = r_valid;

endmodule

// File: tb/tb_sine_term.sv
// Directed bench for sine_term; expected results computed by hand for both rounding builds.
module tb_sine_term;

  logic        clk;
  logic        rst;
  logic        start;
  logic [6:0]  x;
  logic [20:0] x_cube;
  logic [18:0] y;
  logic        valid;
  logic        busy;

  int checks;
  int failures;

`ifdef SINE_ROUND_EN
  localparam logic [18:0] EXP64  = 19'd218453;
  localparam logic [18:0] EXP100 = 19'd242933;
`else
  localparam logic [18:0] EXP64  = 19'd218454;
  localparam logic [18:0] EXP100 = 19'd242934;
`endif
  localparam logic [18:0] EXP127 = 19'd178795;

  sine_term dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .x      (x),
    .x_cube (x_cube),
    .y      (y),
    .valid  (valid),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one start pulse and reports latency (edges after the accepting edge), result and pulse width.
  task automatic do_op(input logic [6:0] xa, input logic [20:0] xca,
                       output logic [18:0] yo, output int lat,
                       output logic busy_n, output logic vld_after);
    @(negedge clk);
    start = 1'b1; x = xa; x_cube = xca;
    @(posedge clk); #1;
    busy_n = busy;
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (valid) begin
        lat = c;
        break;
      end
    end
    yo = y;
    @(posedge clk); #1;
    vld_after = valid;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; x = '0; x_cube = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (y !== 19'd0) begin failures++; $display("FAIL reset_y got=%0d exp=0", y); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [18:0] yo; int lat; logic bn, va;
    do_op(7'd64, 21'd262144, yo, lat, bn, va);
    checks++; if (lat != 23) begin failures++; $display("FAIL basic_latency got=%0d exp=23", lat); end
    checks++; if (yo !== EXP64) begin failures++; $display("FAIL basic_y got=%0d exp=%0d", yo, EXP64); end
    checks++; if (bn !== 1'b1) begin failures++; $display("FAIL basic_busy got=%b exp=1", bn); end
    checks++; if (va !== 1'b0) begin failures++; $display("FAIL basic_valid_width got=%b exp=0", va); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL basic_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_rem1();
    logic [18:0] yo; int lat; logic bn, va;
    do_op(7'd127, 21'd2048383, yo, lat, bn, va);
    checks++; if (lat != 23) begin failures++; $display("FAIL rem1_latency got=%0d exp=23", lat); end
    checks++; if (yo !== EXP127) begin failures++; $display("FAIL rem1_y got=%0d exp=%0d", yo, EXP127); end
  endtask

  task automatic test_small();
    logic [18:0] yo; int lat; logic bn, va;
    do_op(7'd1, 21'd1, yo, lat, bn, va);
    checks++; if (yo !== 19'd4096) begin failures++; $display("FAIL one_y got=%0d exp=4096", yo); end
    checks++; if (lat != 23 || va !== 1'b0) begin failures++; $display("FAIL one_pulse lat=%0d after=%b exp lat=23 after=0", lat, va); end
    do_op(7'd0, 21'd0, yo, lat, bn, va);
    checks++; if (yo !== 19'd0) begin failures++; $display("FAIL zero_y got=%0d exp=0", yo); end
    checks++; if (lat != 23 || va !== 1'b0) begin failures++; $display("FAIL zero_pulse lat=%0d after=%b exp lat=23 after=0", lat, va); end
  endtask

  task automatic test_back_to_back();
    int npulse;
    int pos [3];
    int bad_y;
    npulse = 0; bad_y = 0;
    @(negedge clk);
    start = 1'b1; x = 7'd64; x_cube = 21'd262144;
    for (int c = 1; c <= 75; c++) begin
      @(posedge clk); #1;
      if (valid) begin
        if (npulse < 3) pos[npulse] = c;
        npulse++;
        if (y !== EXP64) bad_y++;
      end
    end
    @(negedge clk);
    start = 1'b0;
    checks++; if (npulse != 3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", npulse); end
    if (npulse >= 3) begin
      checks++; if (pos[0] != 24) begin failures++; $display("FAIL b2b_first got=%0d exp=24", pos[0]); end
      checks++; if (pos[1] != 48) begin failures++; $display("FAIL b2b_second got=%0d exp=48", pos[1]); end
      checks++; if (pos[2] != 72) begin failures++; $display("FAIL b2b_third got=%0d exp=72", pos[2]); end
    end
    checks++; if (bad_y != 0) begin failures++; $display("FAIL b2b_y bad_results=%0d exp=0", bad_y); end
    for (int c = 0; c < 40 && busy; c++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_drain busy=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    logic [18:0] yo; int lat; logic bn, va; int seen;
    @(negedge clk);
    start = 1'b1; x = 7'd64; x_cube = 21'd262144;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checks++; if (y !== EXP64) begin failures++; $display("FAIL hold_y got=%0d exp=%0d", y, EXP64); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (y !== 19'd0) begin failures++; $display("FAIL midrst_y got=%0d exp=0", y); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b exp=0", busy); end
    checks++; if (valid !== 1'b0) begin failures++; $display("FAIL midrst_valid got=%b exp=0", valid); end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (valid || busy) seen++;
    end
    checks++; if (seen != 0) begin failures++; $display("FAIL midrst_quiet active_cycles=%0d exp=0", seen); end
    do_op(7'd127, 21'd2048383, yo, lat, bn, va);
    checks++; if (yo !== EXP127) begin failures++; $display("FAIL postrst_y got=%0d exp=%0d", yo, EXP127); end
    checks++; if (lat != 23) begin failures++; $display("FAIL postrst_latency got=%0d exp=23", lat); end
  endtask

  task automatic test_input_change();
    int lat;
    @(negedge clk);
    start = 1'b1; x = 7'd100; x_cube = 21'd1000000;
    @(posedge clk);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      start = 1'b0;
      x = 7'($urandom);
      x_cube = 21'($urandom);
      @(posedge clk); #1;
      if (valid) begin
        lat = c;
        break;
      end
    end
    checks++; if (lat != 23) begin failures++; $display("FAIL change_latency got=%0d exp=23", lat); end
    checks++; if (y !== EXP100) begin failures++; $display("FAIL change_y got=%0d exp=%0d", y, EXP100); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_rem1();
    test_small();
    test_back_to_back();
    test_reset_mid();
    test_input_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sine_term.md
SINE_TERM -- requirements
Module: sine_term

Interface
REQ-001 SHALL have ports, clock and reset first:
- clk  input  1  single clock; all state changes on its rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- x  input  7  angle, unsigned Q1.6 (value x/64 rad)
- x_cube  input  21  unsigned integer x*x*x, as produced by the upstream cube stage; Q3.18
- y  output  19  sin approximation x - x^3/6, unsigned Q1.18
- valid  output  1  one-cycle pulse; y holds a new result
- busy  output  1  high while a computation is in progress

Function
REQ-002 SHALL use FSM states IDLE, DIV, SUB, DONE.
REQ-003 IDLE with start=1 at an edge SHALL capture x and x_cube, clear quotient/remainder, set bit counter to 20, and go to DIV.
REQ-004 IDLE with start=0 SHALL hold all registers.
REQ-005 DIV SHALL run restoring division of captured x_cube by constant 6, one quotient bit per cycle, MSB (bit 20) first:
- rem = {rem, dividend bit}
- if rem >= 6: subtract 6, set the quotient bit
REQ-006 DIV SHALL last exactly 21 cycles (counter 20 down to 0), then go to SUB.
REQ-007 SUB SHALL compute (x << 12) - quotient into 19-bit y, then go to DONE.
- Result is never negative for any legal input.
- No saturation logic.
REQ-008 DONE SHALL assert valid for exactly one cycle, then go to IDLE.
REQ-009 busy SHALL be high in DIV, SUB and DONE, and low in IDLE.
REQ-010 Latency: start sampled at edge N gives valid=1 and a new y after edge N+23; busy is high from edge N to edge N+23.
REQ-011 start while busy=1 SHALL be ignored and not queued.
- start in the DONE cycle is also ignored.
- start on the first IDLE cycle after DONE is accepted (back-to-back period of 24 cycles).
REQ-012 y SHALL hold its last value until the next SUB; input changes mid-operation SHALL NOT affect the result.
REQ-013 x=0, x_cube=0 SHALL give y=0 with normal latency, with no special-case path.
REQ-014 The block SHALL NOT check that x_cube equals x^3; it computes on the values given.

Reset
REQ-015 rst=1 SHALL immediately force:
- state IDLE
- y=0, valid=0, busy=0
- counter, quotient, remainder and captured inputs to 0
REQ-016 Reset mid-operation SHALL abort the computation, with no valid pulse afterwards.
REQ-017 The first start after rst deasserts SHALL be accepted normally.

Configuration
REQ-018 Macro SINE_ROUND_EN:
- Defined: after the last DIV step, if 2*remainder >= 6, the quotient SHALL be incremented by 1 before SUB (round to nearest). Latency is unchanged.
- Undefined: the quotient is truncated and no rounding logic exists.

Verification
REQ-019 Bench SHALL cover these directed scenarios:
- x=64, x_cube=262144, start pulse -> valid after 23 cycles, y=218454 (218453 with SINE_ROUND_EN).
- x=127, x_cube=2048383 -> y=178795, identical with and without SINE_ROUND_EN (remainder 1).
- x=1, x_cube=1 -> y=4096; x=0, x_cube=0 -> y=0; each with one valid pulse.
- start held high continuously, x=64 -> valid every 24 cycles; start while busy does not change the result or the timing.
- rst asserted at cycle 10 of DIV -> outputs 0 at once, no valid pulse; next start at x=127 -> y=178795.
- x and x_cube changed to random values during DIV -> y matches the values captured at start.
